fetch_controller: RTL and testbench

Instruction-fetch sequencer for the 16-bit pipelined CPU. Owns the program counter, drives the synchronous-read instructionMemory, and fills the IF/ID pipeline register at one instruction per cycle. Handles hazard-unit stalls without losing the in-flight read, branch/jump redirects with flush, and halts fetch on a HALT opcode. Sits between instructionMemory and the decode stage.

---
 rtl/fetch_controller_pkg.sv | 19 +
 rtl/fetch_controller_skid.sv | 47 ++++
 rtl/fetch_controller.sv | 131 +++++++++++++
 tb/tb_fetch_controller.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_controller_pkg.sv
// Shared CPU fetch definitions: opcode field position, fetch constants and state encodings.
package cpu_defs;

    localparam int unsigned   OPC_MSB      = 15;
    localparam int unsigned   OPC_LSB      = 12;
    localparam logic [3:0]    CPU_HALT_OP  = 4'hF;
    localparam logic [15:0]   CPU_PC_STEP  = 16'd2;
    localparam logic [15:0]   CPU_RESET_PC = 16'h0000;

    typedef enum logic {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } fetch_state_e;

    function automatic logic has_opcode(input logic [15:0] instr, input logic [3:0] op);
        return instr[OPC_MSB:OPC_LSB] == op;
    endfunction

endpackage

// File: rtl/fetch_controller_skid.sv
// One-entry holding register that parks an instruction returning while IF/ID is stalled.
module fetch_skid_buffer
    import cpu_defs::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_drain,
    input  logic              i_clear,
    input  logic [DATA_W-1:0] i_instr,
    input  logic [DATA_W-1:0] i_pc,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_instr,
    output logic [DATA_W-1:0] o_pc
);

    logic              r_valid;
    logic [DATA_W-1:0] r_instr;
    logic [DATA_W-1:0] r_pc;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
        end else if (i_drain) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr <= '0;
            r_pc    <= '0;
        end else if (i_load && !i_clear) begin
            r_instr <= i_instr;
            r_pc    <= i_pc;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, drives instruction memory and fills IF/ID.
module fetch_controller
    import cpu_defs::*;
#(
    parameter logic [15:0] RESET_PC = CPU_RESET_PC,
    parameter logic [15:0] PC_STEP  = CPU_PC_STEP,
    parameter logic [3:0]  HALT_OP  = CPU_HALT_OP
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_en,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        if_valid,
    output logic [15:0] if_instr,
    output logic [15:0] if_pc,
    output logic        halted
);

    fetch_state_e r_state, w_state_next;

    logic [15:0] r_pc;
    logic        r_inflight_valid;
    logic [15:0] r_inflight_pc;
    logic        r_if_valid;
    logic [15:0] r_if_instr;
    logic [15:0] r_if_pc;

    logic        w_ret_halt;
    logic        w_issue;
    logic        w_skid_load;
    logic        w_skid_drain;
    logic        w_skid_clear;
    logic        w_skid_valid;
    logic [15:0] w_skid_instr;
    logic [15:0] w_skid_pc;

    assign w_ret_halt = r_inflight_valid && has_opcode(imem_rdata, HALT_OP);

    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_skid_load  = 1'b0;
        w_skid_drain = 1'b0;
        w_skid_clear = 1'b0;
        if (rst) begin
            w_state_next = FETCH;
        end else if (redirect) begin
            w_state_next = FETCH;
            w_skid_clear = 1'b1;
        end else begin
            if (w_ret_halt) begin
                w_state_next = HALTED;
            end
            if (stall) begin
                w_skid_load = r_inflight_valid;
            end else begin
                w_skid_drain = w_skid_valid;
                // a returning HALT blocks the issue in its own cycle: no wrong-path read
                w_issue      = (r_state == FETCH) && !w_ret_halt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc             <= RESET_PC;
            r_inflight_valid <= 1'b0;
            r_inflight_pc    <= '0;
            r_if_valid       <= 1'b0;
            r_if_instr       <= '0;
            r_if_pc          <= '0;
        end else begin
            r_inflight_valid <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= r_pc;
                r_pc          <= r_pc + PC_STEP;
            end
            if (redirect) begin
                r_pc       <= redirect_pc;
                r_if_valid <= 1'b0;
            end else if (!stall) begin
                if (w_skid_valid) begin
                    r_if_valid <= 1'b1;
                    r_if_instr <= w_skid_instr;
                    r_if_pc    <= w_skid_pc;
                end else if (r_inflight_valid) begin
                    r_if_valid <= 1'b1;
                    r_if_instr <= imem_rdata;
                    r_if_pc    <= r_inflight_pc;
                end else begin
                    r_if_valid <= 1'b0;
                end
            end
        end
    end

    fetch_skid_buffer #(
        .DATA_W (16)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_skid_load),
        .i_drain (w_skid_drain),
        .i_clear (w_skid_clear),
        .i_instr (imem_rdata),
        .i_pc    (r_inflight_pc),
        .o_valid (w_skid_valid),
        .o_instr (w_skid_instr),
        .o_pc    (w_skid_pc)
    );

    assign imem_en   = w_issue;
    assign imem_addr = r_pc;
    assign if_valid  = r_if_valid;
    assign if_instr  = r_if_instr;
    assign if_pc     = r_if_pc;
    assign halted    = (r_state == HALTED);

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed timing scenarios plus a randomized in-order delivery scoreboard.
module tb_fetch_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_en;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata = '0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic        halted;

    logic [15:0] mem [0:32767];
    int n_cmp = 0;
    int n_err = 0;

    fetch_controller #(
        .RESET_PC (16'h0000),
        .PC_STEP  (16'd2),
        .HALT_OP  (4'hF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_en     (imem_en),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    // synchronous-read instruction memory
    always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr[15:1]];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; stall = 1'b0; redirect = 1'b0;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; redirect = 1'b0;
        tick();
        n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL reset_if_valid: got %b expected 0", if_valid); end
        n_cmp++; if (if_instr !== 16'h0000) begin n_err++; $display("FAIL reset_if_instr: got %h expected 0000", if_instr); end
        n_cmp++; if (if_pc !== 16'h0000) begin n_err++; $display("FAIL reset_if_pc: got %h expected 0000", if_pc); end
        n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted: got %b expected 0", halted); end
        n_cmp++; if (imem_en !== 1'b0) begin n_err++; $display("FAIL reset_imem_en: got %b expected 0", imem_en); end
        n_cmp++; if (imem_addr !== 16'h0000) begin n_err++; $display("FAIL reset_imem_addr: got %h expected 0000", imem_addr); end
        rst = 1'b0;
        #1;
        n_cmp++; if (imem_en !== 1'b1 || imem_addr !== 16'h0000) begin n_err++; $display("FAIL first_issue: got en=%b addr=%h expected en=1 addr=0000", imem_en, imem_addr); end
        tick();
        n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL r2_bubble: got %b expected 0", if_valid); end
        tick();
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== 16'h0000 || if_instr !== 16'h1234) begin n_err++; $display("FAIL r3_first: got v=%b pc=%h i=%h expected v=1 pc=0000 i=1234", if_valid, if_pc, if_instr); end
        tick();
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== 16'h0002 || if_instr !== 16'h2345) begin n_err++; $display("FAIL r4_second: got v=%b pc=%h i=%h expected v=1 pc=0002 i=2345", if_valid, if_pc, if_instr); end
        tick();
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== 16'h0004 || if_instr !== 16'h3456) begin n_err++; $display("FAIL r5_third: got v=%b pc=%h i=%h expected v=1 pc=0004 i=3456", if_valid, if_pc, if_instr); end
    endtask

    task automatic test_stall();
        do_reset();
        tick(); tick(); tick();
        n_cmp++; if (if_pc !== 16'h0002) begin n_err++; $display("FAIL stall_pre_pc: got %h expected 0002", if_pc); end
        stall = 1'b1;
        #1;
        n_cmp++; if (imem_en !== 1'b0) begin n_err++; $display("FAIL stall_no_issue: got %b expected 0", imem_en); end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++; if (if_valid !== 1'b1 || if_pc !== 16'h0002 || if_instr !== 16'h2345) begin n_err++; $display("FAIL stall_hold_%0d: got v=%b pc=%h i=%h expected v=1 pc=0002 i=2345", k, if_valid, if_pc, if_instr); end
        end
        stall = 1'b0;
        for (int k = 0; k < 3; k++) begin
            logic [15:0] epc;
            epc = 16'h0004 + 16'(2 * k);
            tick();
            n_cmp++; if (if_valid !== 1'b1 || if_pc !== epc || if_instr !== mem[epc[15:1]]) begin n_err++; $display("FAIL stall_resume_%0d: got v=%b pc=%h i=%h expected v=1 pc=%h i=%h", k, if_valid, if_pc, if_instr, epc, mem[epc[15:1]]); end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        tick(); tick(); tick(); tick();
        redirect = 1'b1; redirect_pc = 16'h002C;
        #1;
        n_cmp++; if (imem_en !== 1'b0) begin n_err++; $display("FAIL redir_no_issue: got %b expected 0", imem_en); end
        tick();
        redirect = 1'b0;
        #1;
        n_cmp++; if (if_valid !== 1'b0 || imem_addr !== 16'h002C || imem_en !== 1'b1) begin n_err++; $display("FAIL redir_n1: got v=%b addr=%h en=%b expected v=0 addr=002c en=1", if_valid, imem_addr, imem_en); end
        tick();
        n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL redir_n2: got v=%b expected 0", if_valid); end
        tick();
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== 16'h002C || if_instr !== mem[16'h0016]) begin n_err++; $display("FAIL redir_n3: got v=%b pc=%h i=%h expected v=1 pc=002c i=%h", if_valid, if_pc, if_instr, mem[16'h0016]); end
        tick();
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== 16'h002E || if_instr !== mem[16'h0017]) begin n_err++; $display("FAIL redir_n4: got v=%b pc=%h i=%h expected v=1 pc=002e i=%h", if_valid, if_pc, if_instr, mem[16'h0017]); end
    endtask

    task automatic test_halt();
        do_reset();
        redirect = 1'b1; redirect_pc = 16'h0030;
        tick();
        redirect = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            logic [15:0] epc;
            epc = 16'h0030 + 16'(2 * k);
            tick();
            n_cmp++; if (if_valid !== 1'b1 || if_pc !== epc) begin n_err++; $display("FAIL halt_pre_%0d: got v=%b pc=%h expected v=1 pc=%h", k, if_valid, if_pc, epc); end
        end
        n_cmp++; if (imem_en !== 1'b0 || halted !== 1'b0) begin n_err++; $display("FAIL halt_ret_cycle: got en=%b halted=%b expected en=0 halted=0", imem_en, halted); end
        tick();
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== 16'h0038 || if_instr !== 16'hF000 || halted !== 1'b1) begin n_err++; $display("FAIL halt_deliver: got v=%b pc=%h i=%h h=%b expected v=1 pc=0038 i=f000 h=1", if_valid, if_pc, if_instr, halted); end
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (imem_en !== 1'b0) begin n_err++; $display("FAIL halt_en_%0d: got %b expected 0", k, imem_en); end
            tick();
            n_cmp++; if (if_valid !== 1'b0 || halted !== 1'b1) begin n_err++; $display("FAIL halt_idle_%0d: got v=%b h=%b pc=%h expected v=0 h=1", k, if_valid, halted, if_pc); end
        end
        redirect = 1'b1; redirect_pc = 16'h000C;
        tick();
        redirect = 1'b0;
        #1;
        n_cmp++; if (halted !== 1'b0 || imem_en !== 1'b1 || imem_addr !== 16'h000C) begin n_err++; $display("FAIL halt_exit: got h=%b en=%b addr=%h expected h=0 en=1 addr=000c", halted, imem_en, imem_addr); end
        tick(); tick();
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== 16'h000C) begin n_err++; $display("FAIL halt_resume: got v=%b pc=%h expected v=1 pc=000c", if_valid, if_pc); end
    endtask

    task automatic test_redirect_stall();
        do_reset();
        tick(); tick(); tick();
        stall = 1'b1;
        tick();
        redirect = 1'b1; redirect_pc = 16'h0100;
        tick();
        redirect = 1'b0; stall = 1'b0;
        #1;
        n_cmp++; if (if_valid !== 1'b0 || imem_addr !== 16'h0100) begin n_err++; $display("FAIL rs_flush: got v=%b addr=%h expected v=0 addr=0100", if_valid, imem_addr); end
        tick();
        n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL rs_bubble: got v=%b pc=%h expected v=0", if_valid, if_pc); end
        tick();
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== 16'h0100 || if_instr !== mem[16'h0080]) begin n_err++; $display("FAIL rs_first: got v=%b pc=%h i=%h expected v=1 pc=0100 i=%h", if_valid, if_pc, if_instr, mem[16'h0080]); end
        tick();
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== 16'h0102) begin n_err++; $display("FAIL rs_second: got v=%b pc=%h expected v=1 pc=0102", if_valid, if_pc); end
    endtask

    task automatic test_wrap();
        do_reset();
        redirect = 1'b1; redirect_pc = 16'hFFFC;
        tick();
        redirect = 1'b0;
        tick(); tick();
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== 16'hFFFC) begin n_err++; $display("FAIL wrap_fffc: got v=%b pc=%h expected v=1 pc=fffc", if_valid, if_pc); end
        tick();
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== 16'hFFFE || if_instr !== mem[16'h7FFF]) begin n_err++; $display("FAIL wrap_fffe: got v=%b pc=%h i=%h expected v=1 pc=fffe i=%h", if_valid, if_pc, if_instr, mem[16'h7FFF]); end
        tick();
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== 16'h0000 || if_instr !== 16'h1234) begin n_err++; $display("FAIL wrap_0000: got v=%b pc=%h i=%h expected v=1 pc=0000 i=1234", if_valid, if_pc, if_instr); end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        tick(); tick(); tick();
        stall = 1'b1;
        tick(); tick();
        rst = 1'b1;
        tick();
        n_cmp++; if (if_valid !== 1'b0 || if_instr !== 16'h0000 || if_pc !== 16'h0000 || halted !== 1'b0 || imem_en !== 1'b0 || imem_addr !== 16'h0000) begin n_err++; $display("FAIL rst_stall: got v=%b i=%h pc=%h h=%b en=%b addr=%h expected all zero", if_valid, if_instr, if_pc, halted, imem_en, imem_addr); end
        rst = 1'b0; stall = 1'b0;
        tick();
        n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL rst_skid_discard: got v=%b pc=%h expected v=0", if_valid, if_pc); end
        tick();
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== 16'h0000 || if_instr !== 16'h1234) begin n_err++; $display("FAIL rst_restart: got v=%b pc=%h i=%h expected v=1 pc=0000 i=1234", if_valid, if_pc, if_instr); end
    endtask

    // Reference: after rst/redirect, deliveries are the consecutive addresses from the start
    // point, in order, none skipped or repeated, none after a HALT, at most one bubble per gap.
    task automatic test_random();
        logic [15:0] exp_pc, rpc, s_i, s_p, word;
        logic        exp_halt, k_rst, k_red, k_stall, s_v;
        int unsigned bubbles;
        for (int i = 0; i < 40; i++) mem[$urandom_range(64, 32767)] = {4'hF, 12'($urandom)};
        do_reset();
        exp_pc = 16'h0000; exp_halt = 1'b0; bubbles = 0;
        for (int c = 0; c < 3000; c++) begin
            k_rst   = ($urandom_range(0, 199) == 0);
            k_red   = ($urandom_range(0, 99) < 4);
            k_stall = ($urandom_range(0, 99) < 30);
            rpc     = 16'($urandom) & 16'hFFFE;
            rst = k_rst; redirect = k_red; stall = k_stall; redirect_pc = rpc;
            #1;
            if (k_rst || k_red || k_stall || halted) begin
                n_cmp++; if (imem_en !== 1'b0) begin n_err++; $display("FAIL rnd_en_blocked c=%0d: got %b expected 0", c, imem_en); end
            end
            s_v = if_valid; s_i = if_instr; s_p = if_pc;
            tick();
            if (k_rst) begin
                n_cmp++; if (if_valid !== 1'b0 || halted !== 1'b0 || imem_addr !== 16'h0000) begin n_err++; $display("FAIL rnd_rst c=%0d: got v=%b h=%b addr=%h expected 0 0 0000", c, if_valid, halted, imem_addr); end
                exp_pc = 16'h0000; exp_halt = 1'b0; bubbles = 0;
            end else if (k_red) begin
                n_cmp++; if (if_valid !== 1'b0 || halted !== 1'b0 || imem_addr !== rpc) begin n_err++; $display("FAIL rnd_redir c=%0d: got v=%b h=%b addr=%h expected 0 0 %h", c, if_valid, halted, imem_addr, rpc); end
                exp_pc = rpc; exp_halt = 1'b0; bubbles = 0;
            end else if (k_stall) begin
                n_cmp++; if (if_valid !== s_v || if_instr !== s_i || if_pc !== s_p) begin n_err++; $display("FAIL rnd_hold c=%0d: got v=%b pc=%h i=%h expected v=%b pc=%h i=%h", c, if_valid, if_pc, if_instr, s_v, s_p, s_i); end
            end else begin
                if (if_valid) begin
                    word = mem[exp_pc[15:1]];
                    n_cmp++; if (exp_halt) begin n_err++; $display("FAIL rnd_after_halt c=%0d: got pc=%h expected no delivery", c, if_pc); end
                    n_cmp++; if (if_pc !== exp_pc || if_instr !== word) begin n_err++; $display("FAIL rnd_order c=%0d: got pc=%h i=%h expected pc=%h i=%h", c, if_pc, if_instr, exp_pc, word); end
                    if (word[15:12] == 4'hF) exp_halt = 1'b1;
                    exp_pc = exp_pc + 16'd2;
                    bubbles = 0;
                end else if (!exp_halt) begin
                    bubbles++;
                    n_cmp++; if (bubbles > 1) begin n_err++; $display("FAIL rnd_bubbles c=%0d: got %0d expected <=1", c, bubbles); end
                end
                if (exp_halt) begin
                    n_cmp++; if (halted !== 1'b1) begin n_err++; $display("FAIL rnd_halted c=%0d: got %b expected 1", c, halted); end
                end
            end
        end
        rst = 1'b0; redirect = 1'b0; stall = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
        mem[0] = 16'h1234;
        mem[1] = 16'h2345;
        mem[2] = 16'h3456;
        mem[16'h001C] = 16'hF000;
        test_reset();
        test_stall();
        test_redirect();
        test_halt();
        test_redirect_stall();
        test_wrap();
        test_reset_mid_stall();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
